// File: rtl/spike_pipe_packer.sv
// Packs spike events and sim-tick markers into 16-bit words and serves them to a pipe-out endpoint.
// Latency: a word is queued the cycle after its event; ep_datain is valid the cycle after ep_read.
// Backpressure: none upstream; writes into a full FIFO are dropped and counted, empty reads flag underrun.
module spike_pipe_packer #(
  parameter int NN          = 8,
  parameter int DEPTH       = 1024,
  parameter int BLOCK_WORDS = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    tick,
  input  logic                    spike,
  input  logic [NN-1:0]           spike_index,
  input  logic                    ep_read,
  output logic [15:0]             ep_datain,
  output logic                    ep_ready,
  output logic [$clog2(DEPTH):0]  fill_level,
  output logic [15:0]             drop_cnt,
  output logic                    underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic [14:0]   tick_cnt_q, tick_cnt_d;
  logic          mark_pend_q, mark_pend_d;
  logic [15:0]   ep_datain_q, ep_datain_d;
  logic          ep_ready_q, ep_ready_d;
  logic          underrun_q, underrun_d;

  logic          spike_en, tick_en;
  logic          fifo_empty, fifo_full;
  logic          do_pop, wr_req, wr_ok, wr_drop, mark_try;
  logic [14:0]   idx_ext;
  logic [15:0]   wr_word;

  // Event decode, write arbitration (spike beats marker) and FIFO bookkeeping
  always_comb begin
    spike_en   = spike & enable;
    tick_en    = tick & enable;
    fifo_empty = (fill_q == '0);
    fifo_full  = (fill_q == FW'(DEPTH));
    idx_ext    = 15'(spike_index);

    do_pop   = ep_read & ~fifo_empty;
    mark_try = mark_pend_q & ~spike_en;
    wr_req   = spike_en | mark_pend_q;
    wr_word  = spike_en ? {1'b1, idx_ext} : {1'b0, tick_cnt_q};
    // A full FIFO with a concurrent read always has a pop, so the write fits.
    wr_ok    = wr_req & (~fifo_full | ep_read);
    wr_drop  = wr_req & ~wr_ok;

    wr_ptr_d = wr_ok  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

    fill_d = fill_q;
    if (wr_ok && !do_pop)      fill_d = fill_q + FW'(1);
    else if (!wr_ok && do_pop) fill_d = fill_q - FW'(1);

    drop_cnt_d = drop_cnt_q;
    if (wr_drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;

    // A new tick re-arms the marker even if the pending one goes out this cycle.
    tick_cnt_d  = tick_en ? tick_cnt_q + 15'd1 : tick_cnt_q;
    mark_pend_d = mark_pend_q;
    if (mark_try) mark_pend_d = 1'b0;
    if (tick_en)  mark_pend_d = 1'b1;

    ep_datain_d = ep_datain_q;
    if (do_pop)       ep_datain_d = mem_q[rd_ptr_q];
    else if (ep_read) ep_datain_d = 16'hDEAD;

    underrun_d = underrun_q | (ep_read & fifo_empty);
    ep_ready_d = (fill_d >= FW'(BLOCK_WORDS));
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      drop_cnt_q  <= '0;
      tick_cnt_q  <= '0;
      mark_pend_q <= 1'b0;
      ep_datain_q <= 16'h0000;
      ep_ready_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      drop_cnt_q  <= drop_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      mark_pend_q <= mark_pend_d;
      ep_datain_q <= ep_datain_d;
      ep_ready_q  <= ep_ready_d;
      underrun_q  <= underrun_d;
    end
  end

  // Word storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (wr_ok && !reset) mem_q[wr_ptr_q] <= wr_word;
  end

  assign ep_datain  = ep_datain_q;
  assign ep_ready   = ep_ready_q;
  assign fill_level = fill_q;
  assign drop_cnt   = drop_cnt_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_spike_pipe_packer.sv
// Bench for spike_pipe_packer: directed scenarios plus randomized traffic against a queue model.
// Runs the DUT with a small FIFO so full, drop and wrap cases are reachable quickly.
// Outputs are sampled 1 time unit after each rising edge.
module tb_spike_pipe_packer;

  localparam int NN    = 8;
  localparam int DEPTH = 16;
  localparam int BLOCK = 8;

  logic        clk = 1'b0;
  logic        reset, enable, tick, spike, ep_read;
  logic [7:0]  spike_index;
  logic [15:0] ep_datain;
  logic        ep_ready;
  logic [4:0]  fill_level;
  logic [15:0] drop_cnt;
  logic        underrun;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [15:0] mq[$];
  logic [14:0] m_tcnt;
  bit          m_pend;
  logic [15:0] m_drop;
  logic [15:0] m_dat;
  bit          m_und;

  spike_pipe_packer #(.NN(NN), .DEPTH(DEPTH), .BLOCK_WORDS(BLOCK)) dut (
    .clk(clk), .reset(reset), .enable(enable), .tick(tick), .spike(spike),
    .spike_index(spike_index), .ep_read(ep_read), .ep_datain(ep_datain),
    .ep_ready(ep_ready), .fill_level(fill_level), .drop_cnt(drop_cnt), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic model_step(input bit r, e, t, s, input logic [7:0] ix, input bit rd);
    bit have_w;
    bit is_mark;
    logic [15:0] w;
    if (r) begin
      mq.delete(); m_tcnt = '0; m_pend = 0; m_drop = '0; m_dat = '0; m_und = 0;
      return;
    end
    have_w = 0; is_mark = 0; w = '0;
    if (s && e) begin have_w = 1; w = {8'h80, ix}; end
    else if (m_pend) begin have_w = 1; is_mark = 1; w = {1'b0, m_tcnt}; end
    if (rd && mq.size() > 0) m_dat = mq.pop_front();
    else if (rd) begin m_dat = 16'hDEAD; m_und = 1; end
    if (have_w) begin
      if (mq.size() < DEPTH) mq.push_back(w);
      else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      if (is_mark) m_pend = 0;
    end
    if (t && e) begin m_tcnt = m_tcnt + 15'd1; m_pend = 1; end
  endtask

  function automatic logic [38:0] exp_vec();
    logic [4:0] sz;
    sz = 5'(mq.size());
    return {m_dat, sz, (mq.size() >= BLOCK), m_drop, m_und};
  endfunction

  task automatic cyc(input bit r, e, t, s, input logic [7:0] ix, input bit rd);
    reset = r; enable = e; tick = t; spike = s; spike_index = ix; ep_read = rd;
    @(posedge clk);
    model_step(r, e, t, s, ix, rd);
    #1;
  endtask

  task automatic idle(); cyc(0, 1, 0, 0, 8'h00, 0); endtask
  task automatic rd1();  cyc(0, 1, 0, 0, 8'h00, 1); endtask

  task automatic test_reset();
    cyc(1, 1, 1, 1, 8'hAA, 1);
    cyc(1, 1, 1, 1, 8'h55, 1);
    n_cmp++;
    if ({ep_datain, fill_level, ep_ready, drop_cnt, underrun} !== 39'd0) begin
      n_bad++;
      $display("FAIL reset_state: got %h required 0", {ep_datain, fill_level, ep_ready, drop_cnt, underrun});
    end
  endtask

  task automatic test_spike();
    cyc(1, 1, 0, 0, 8'h00, 0);
    cyc(0, 1, 0, 1, 8'h05, 0);
    n_cmp++;
    if (fill_level !== 5'd1 || ep_ready !== 1'b0) begin
      n_bad++; $display("FAIL spike_fill: fill=%0d ready=%b required 1/0", fill_level, ep_ready);
    end
    rd1();
    n_cmp++;
    if (ep_datain !== 16'h8005) begin
      n_bad++; $display("FAIL spike_word: got %h required 8005", ep_datain);
    end
  endtask

  task automatic test_ticks();
    logic [15:0] exp_w [3];
    exp_w[0] = 16'h0001; exp_w[1] = 16'h0002; exp_w[2] = 16'h0003;
    cyc(1, 1, 0, 0, 8'h00, 0);
    repeat (3) cyc(0, 1, 1, 0, 8'h00, 0);
    idle();
    for (int i = 0; i < 3; i++) begin
      rd1();
      n_cmp++;
      if (ep_datain !== exp_w[i]) begin
        n_bad++; $display("FAIL tick_marker%0d: got %h required %h", i, ep_datain, exp_w[i]);
      end
    end
  endtask

  task automatic test_spike_tick_same();
    cyc(1, 1, 0, 0, 8'h00, 0);
    cyc(0, 1, 1, 1, 8'h12, 0);
    idle();
    rd1();
    n_cmp++;
    if (ep_datain !== 16'h8012) begin
      n_bad++; $display("FAIL same_cycle_spike: got %h required 8012", ep_datain);
    end
    rd1();
    n_cmp++;
    if (ep_datain !== 16'h0001) begin
      n_bad++; $display("FAIL same_cycle_marker: got %h required 0001", ep_datain);
    end
  endtask

  task automatic test_fill_drop();
    int ef, ed;
    cyc(1, 1, 0, 0, 8'h00, 0);
    for (int i = 1; i <= 20; i++) begin
      cyc(0, 1, 0, 1, 8'(i), 0);
      ef = (i > DEPTH) ? DEPTH : i;
      ed = (i > DEPTH) ? i - DEPTH : 0;
      n_cmp++;
      if (ep_ready !== (i >= BLOCK) || fill_level !== 5'(ef) || drop_cnt !== 16'(ed)) begin
        n_bad++;
        $display("FAIL fill_drop@%0d: ready=%b fill=%0d drop=%0d required %b/%0d/%0d",
                 i, ep_ready, fill_level, drop_cnt, (i >= BLOCK), ef, ed);
      end
    end
    // full with concurrent read: write accepted, level unchanged, no drop
    cyc(0, 1, 0, 1, 8'h77, 1);
    n_cmp++;
    if (fill_level !== 5'd16 || drop_cnt !== 16'd4 || ep_datain !== 16'h8001) begin
      n_bad++;
      $display("FAIL full_rw: fill=%0d drop=%0d dat=%h required 16/4/8001", fill_level, drop_cnt, ep_datain);
    end
  endtask

  task automatic test_underrun();
    cyc(1, 1, 0, 0, 8'h00, 0);
    rd1();
    n_cmp++;
    if (ep_datain !== 16'hDEAD || underrun !== 1'b1 || fill_level !== 5'd0) begin
      n_bad++; $display("FAIL empty_read: dat=%h und=%b fill=%0d required DEAD/1/0", ep_datain, underrun, fill_level);
    end
    cyc(1, 1, 0, 0, 8'h00, 0);
    n_cmp++;
    if (underrun !== 1'b0) begin
      n_bad++; $display("FAIL underrun_clear: got %b required 0", underrun);
    end
    // empty read with concurrent write: still an underrun, word stays queued
    cyc(0, 1, 0, 1, 8'h3C, 1);
    n_cmp++;
    if (ep_datain !== 16'hDEAD || underrun !== 1'b1 || fill_level !== 5'd1) begin
      n_bad++; $display("FAIL empty_read_write: dat=%h und=%b fill=%0d required DEAD/1/1", ep_datain, underrun, fill_level);
    end
    rd1();
    n_cmp++;
    if (ep_datain !== 16'h803C) begin
      n_bad++; $display("FAIL queued_after_underrun: got %h required 803C", ep_datain);
    end
  endtask

  task automatic test_reset_mid_block();
    cyc(1, 1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 8'(8'h40 + i), 0);
    rd1(); rd1();
    cyc(1, 1, 1, 1, 8'h99, 1);
    n_cmp++;
    if (fill_level !== 5'd0 || ep_ready !== 1'b0 || ep_datain !== 16'h0000) begin
      n_bad++; $display("FAIL reset_mid_block: fill=%0d ready=%b dat=%h required 0/0/0000", fill_level, ep_ready, ep_datain);
    end
    cyc(0, 1, 1, 1, 8'h33, 0);
    idle();
    rd1();
    n_cmp++;
    if (ep_datain !== 16'h8033) begin
      n_bad++; $display("FAIL post_reset_spike: got %h required 8033", ep_datain);
    end
    rd1();
    n_cmp++;
    if (ep_datain !== 16'h0001) begin
      n_bad++; $display("FAIL post_reset_marker: got %h required 0001", ep_datain);
    end
  endtask

  task automatic test_tick_wrap();
    cyc(1, 1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 32772; i++) begin
      cyc(0, 1, 1, 0, 8'h00, 1);
      if (i > 32760) begin
        n_cmp++;
        if ({ep_datain, fill_level, ep_ready, drop_cnt, underrun} !== exp_vec()) begin
          n_bad++;
          $display("FAIL tick_wrap@%0d: got %h required %h", i,
                   {ep_datain, fill_level, ep_ready, drop_cnt, underrun}, exp_vec());
        end
      end
    end
  endtask

  task automatic test_random();
    int rp;
    bit r, e, t, s, rd;
    cyc(1, 1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 3000; i++) begin
      case ((i / 500) % 3)
        0:       rp = 10;
        1:       rp = 50;
        default: rp = 90;
      endcase
      r  = ($urandom_range(999) < 3);
      e  = ($urandom_range(99) < 90);
      t  = ($urandom_range(99) < 20);
      s  = ($urandom_range(99) < 40);
      rd = ($urandom_range(99) < rp);
      cyc(r, e, t, s, 8'($urandom), rd);
      n_cmp++;
      if ({ep_datain, fill_level, ep_ready, drop_cnt, underrun} !== exp_vec()) begin
        n_bad++;
        $display("FAIL random@%0d: got %h required %h", i,
                 {ep_datain, fill_level, ep_ready, drop_cnt, underrun}, exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; tick = 1'b0; spike = 1'b0; spike_index = '0; ep_read = 1'b0;
    test_reset();
    test_spike();
    test_ticks();
    test_spike_tick_same();
    test_fill_drop();
    test_underrun();
    test_reset_mid_block();
    test_tick_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
